// File: rtl/oled_i2c_slave_if.sv
// oled_i2c_slave_if -- bus bundle for the OLED I2C write-only target.
//
// Signals:
//   scl_in, sda_in   raw I2C bus levels (asynchronous to clk)
//   sda_out          open-drain low level (always 0)
//   sda_oen          1 = pull SDA low (ACK), 0 = release
//   byte_valid       one-clk pulse: byte_data/byte_dc hold a new received byte
//   byte_dc          D/C# of byte_data: 0 = command, 1 = GDDRAM data
//   byte_data        received byte, held until the next byte_valid
//   busy             target addressed (address ACK until STOP / mismatching START)
//   frame_done       one-clk pulse on STOP ending an addressed transaction
//
// Modports: slave (the target block), master (the bus side / bench).
interface oled_i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic       sda_oen;
  logic       byte_valid;
  logic       byte_dc;
  logic [7:0] byte_data;
  logic       busy;
  logic       frame_done;

  modport slave (
    input  scl_in, sda_in,
    output sda_out, sda_oen, byte_valid, byte_dc, byte_data, busy, frame_done
  );

  modport master (
    output scl_in, sda_in,
    input  sda_out, sda_oen, byte_valid, byte_dc, byte_data, busy, frame_done
  );
endinterface

// File: rtl/oled_i2c_slave.sv
// oled_i2c_slave -- write-only I2C target for an SSD1306-style OLED controller.
//
// Receives {addr,W}, then control bytes (bit7 = Co, bit6 = D/C#) each followed
// by one data byte (Co=1) or by a stream of data bytes (Co=0). Every accepted
// byte is ACKed; data bytes are presented on byte_valid/byte_data/byte_dc.
// Reads and foreign addresses are ignored (never ACKed) until START/STOP.
//
// Ports:
//   clk    system clock (single domain)
//   rst_n  asynchronous active-low reset
//   bus    oled_i2c_slave_if.slave (I2C pins and received-byte outputs)
//
// Parameter:
//   OLED_CHIP_ADDR  7-bit target address answered (default 7'h3C)
//
// Configuration macro:
//   OLED_I2C_SLAVE_GLITCH_FILTER_EN  adds a 3-sample majority filter behind
//   each synchroniser (+2 clk latency, rejects 1-clk pulses).
module oled_i2c_slave #(
  parameter logic [6:0] OLED_CHIP_ADDR = 7'h3C
) (
  input  logic              clk,
  input  logic              rst_n,
  oled_i2c_slave_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_s;
  logic       sda_s;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], bus.scl_in};
      sda_sync_r <= {sda_sync_r[0], bus.sda_in};
    end
  end

`ifdef OLED_I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r;
  logic [1:0] sda_hist_r;
  logic       scl_flt_r;
  logic       sda_flt_r;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Majority of the last three synchronised samples; a lone 1-clk pulse never
  // forms a majority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      scl_flt_r  <= maj3({scl_hist_r, scl_sync_r[1]});
      sda_flt_r  <= maj3({sda_hist_r, sda_sync_r[1]});
    end
  end

  assign scl_s = scl_flt_r;
  assign sda_s = sda_flt_r;
`else
  assign scl_s = scl_sync_r[1];
  assign sda_s = sda_sync_r[1];
`endif

  // ---------------------------------------------------------------------------
  // Bus event detection
  // ---------------------------------------------------------------------------
  logic scl_d_r;
  logic sda_d_r;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  // Previous conditioned levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_r <= 1'b1;
      sda_d_r <= 1'b1;
    end else begin
      scl_d_r <= scl_s;
      sda_d_r <= sda_s;
    end
  end

  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  // SCL must be high in both samples, so an SDA change coincident with SCL
  // rising is data. START needs SDA falling, STOP rising: mutually exclusive.
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t     state_r,      state_nxt;
  logic [3:0] bit_cnt_r,    bit_cnt_nxt;
  logic [7:0] shift_r,      shift_nxt;
  logic       co_r,         co_nxt;
  logic       dc_r,         dc_nxt;
  logic       oen_r,        oen_nxt;
  logic       busy_r,       busy_nxt;
  logic       valid_r,      valid_nxt;
  logic       byte_dc_r,    byte_dc_nxt;
  logic [7:0] byte_data_r,  byte_data_nxt;
  logic       frame_done_r, frame_done_nxt;

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      co_r         <= 1'b0;
      dc_r         <= 1'b0;
      oen_r        <= 1'b0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      byte_dc_r    <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      shift_r      <= shift_nxt;
      co_r         <= co_nxt;
      dc_r         <= dc_nxt;
      oen_r        <= oen_nxt;
      busy_r       <= busy_nxt;
      valid_r      <= valid_nxt;
      byte_dc_r    <= byte_dc_nxt;
      byte_data_r  <= byte_data_nxt;
      frame_done_r <= frame_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state_r;
    bit_cnt_nxt    = bit_cnt_r;
    shift_nxt      = shift_r;
    co_nxt         = co_r;
    dc_nxt         = dc_r;
    oen_nxt        = oen_r;
    busy_nxt       = busy_r;
    valid_nxt      = 1'b0;
    byte_dc_nxt    = byte_dc_r;
    byte_data_nxt  = byte_data_r;
    frame_done_nxt = 1'b0;

    if (stop_s) begin
      state_nxt      = IDLE;
      bit_cnt_nxt    = 4'd0;
      oen_nxt        = 1'b0;
      busy_nxt       = 1'b0;
      frame_done_nxt = busy_r;
    end else if (start_s) begin
      // busy survives a repeated START until the address byte decides.
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      oen_nxt     = 1'b0;
    end else begin
      case (state_r)
        ADDR, CTRL, DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_nxt   = {shift_r[6:0], sda_s};
            bit_cnt_nxt = bit_cnt_r + 4'd1;
            if ((state_r == DATA) && (bit_cnt_r == 4'd7)) begin
              valid_nxt     = 1'b1;
              byte_data_nxt = {shift_r[6:0], sda_s};
              byte_dc_nxt   = dc_r;
            end else begin
              valid_nxt = 1'b0;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            // Falling edge ending bit 8: enter the ACK slot (or give up).
            bit_cnt_nxt = 4'd0;
            case (state_r)
              ADDR: begin
                if (shift_r == {OLED_CHIP_ADDR, 1'b0}) begin
                  state_nxt = ADDR_ACK;
                  oen_nxt   = 1'b1;
                  busy_nxt  = 1'b1;
                end else begin
                  state_nxt = IGNORE;
                  busy_nxt  = 1'b0;
                end
              end
              CTRL: begin
                state_nxt = CTRL_ACK;
                oen_nxt   = 1'b1;
                co_nxt    = shift_r[7];
                dc_nxt    = shift_r[6];
              end
              default: begin
                state_nxt = DATA_ACK;
                oen_nxt   = 1'b1;
              end
            endcase
          end else begin
            bit_cnt_nxt = bit_cnt_r;
          end
        end
        ADDR_ACK, CTRL_ACK, DATA_ACK: begin
          // The falling edge after the ACK clock releases SDA.
          if (scl_fall_s) begin
            oen_nxt = 1'b0;
            case (state_r)
              ADDR_ACK: state_nxt = CTRL;
              CTRL_ACK: state_nxt = DATA;
              default:  state_nxt = co_r ? CTRL : DATA;
            endcase
          end else begin
            state_nxt = state_r;
          end
        end
        IDLE, IGNORE: begin
          state_nxt = state_r;
          oen_nxt   = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          oen_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_out    = 1'b0;
  assign bus.sda_oen    = oen_r;
  assign bus.byte_valid = valid_r;
  assign bus.byte_dc    = byte_dc_r;
  assign bus.byte_data  = byte_data_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_oled_i2c_slave.sv
// tb_oled_i2c_slave -- bit-banged I2C master driving oled_i2c_slave.
// Expected data bytes come from a frame-level reference model and are queued;
// a monitor pops and compares them whenever byte_valid is seen.
module tb_oled_i2c_slave;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic clk;
  logic rst_n;
  logic sda_drv;

  oled_i2c_slave_if bus();

  // Open-drain bus: SDA is low if either side pulls it down.
  assign bus.sda_in = sda_drv & ~bus.sda_oen;

  oled_i2c_slave #(.OLED_CHIP_ADDR(7'h3C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int oen_cnt = 0;
  logic [8:0] sb[$];        // {dc, data}
  logic [7:0] frm[8];
  int exp_ack[8];
  bit glitch_en = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on every byte_valid cycle, plus event counters.
  always @(negedge clk) begin
    if (bus.frame_done) fd_cnt++;
    if (bus.sda_oen) oen_cnt++;
    if (bus.byte_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected got dc=%0d data=%h", bus.byte_dc, bus.byte_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        if ({bus.byte_dc, bus.byte_data} != e) begin
          errors++;
          $display("FAIL byte got dc=%0d data=%h exp dc=%0d data=%h",
                   bus.byte_dc, bus.byte_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model over a whole frame: which bytes get ACKed and which
  // (dc, data) pairs must come out.
  task automatic build_expect(input int n);
    int mode;  // 0: next byte is control, 1: one data byte, 2: data until end
    logic dc;
    dc = 1'b0;
    mode = 0;
    for (int i = 0; i < 8; i++) exp_ack[i] = 0;
    if (n > 0 && frm[0] == 8'h78) begin
      exp_ack[0] = 1;
      for (int i = 1; i < n; i++) begin
        exp_ack[i] = 1;
        if (mode == 0) begin
          dc = frm[i][6];
          mode = frm[i][7] ? 1 : 2;
        end else begin
          sb.push_back({dc, frm[i]});
          if (mode == 1) mode = 0;
        end
      end
    end
  endtask

  task automatic do_start();
    sda_drv = 1'b1; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
  endtask

  task automatic do_stop();
    sda_drv = 1'b0; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    sda_drv = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      sda_drv = b[i]; wait_clk(Q);
      bus.scl_in = 1'b1; wait_clk(2 * Q);
      bus.scl_in = 1'b0;
      if (glitch_en && i == 4) begin
        wait_clk(Q / 2);
        bus.scl_in = 1'b1; wait_clk(1);
        bus.scl_in = 1'b0; wait_clk(Q / 2);
      end else begin
        wait_clk(Q);
      end
    end
  endtask

  task automatic ack_slot(output int a);
    sda_drv = 1'b1; wait_clk(Q);
    bus.scl_in = 1'b1; wait_clk(Q);
    a = int'(bus.sda_oen);
    wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
  endtask

  task automatic run_frame(input int n, input int partial);
    int fd_base, oen_base, a;
    build_expect(n);
    fd_base = fd_cnt;
    oen_base = oen_cnt;
    do_start();
    for (int i = 0; i < n; i++) begin
      send_bits(frm[i], 8);
      ack_slot(a);
      check($sformatf("ack[%0d]=%h", i, frm[i]), a, exp_ack[i]);
      check("busy_in_frame", int'(bus.busy), exp_ack[0]);
    end
    if (partial > 0) send_bits(8'hF0, partial);
    do_stop();
    wait_clk(12);
    check("busy_after_stop", int'(bus.busy), 0);
    check("frame_done_count", fd_cnt - fd_base, exp_ack[0]);
    check("oen_seen", int'(oen_cnt != oen_base), exp_ack[0]);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int a, n;
    rst_n = 1'b0;
    sda_drv = 1'b1;
    bus.scl_in = 1'b1;
    wait_clk(4);
    check("rst_oen", int'(bus.sda_oen), 0);
    check("rst_valid", int'(bus.byte_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_fd", int'(bus.frame_done), 0);
    check("rst_data", int'(bus.byte_data), 0);
    check("rst_dc", int'(bus.byte_dc), 0);
    check("sda_out", int'(bus.sda_out), 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Command stream.
    frm[0] = 8'h78; frm[1] = 8'h00; frm[2] = 8'hAE; frm[3] = 8'hD5; frm[4] = 8'h80;
    run_frame(5, 0);
    // Data stream.
    frm[0] = 8'h78; frm[1] = 8'h40; frm[2] = 8'hFF; frm[3] = 8'h00; frm[4] = 8'hAA;
    run_frame(5, 0);
    // Co=1: one command, then a new control byte switching to data.
    frm[0] = 8'h78; frm[1] = 8'h80; frm[2] = 8'hAF; frm[3] = 8'hC0; frm[4] = 8'h55;
    run_frame(5, 0);
    // Foreign address and read request.
    frm[0] = 8'h7A; frm[1] = 8'h40; frm[2] = 8'h12;
    run_frame(3, 0);
    frm[0] = 8'h79; frm[1] = 8'h00; frm[2] = 8'hAE;
    run_frame(3, 0);
    // Partial byte discarded, then the block answers again.
    frm[0] = 8'h78; frm[1] = 8'h40;
    run_frame(2, 4);
    frm[0] = 8'h78; frm[1] = 8'h00; frm[2] = 8'hA5;
    run_frame(3, 0);

    // Reset during DATA_ACK.
    do_start();
    send_bits(8'h78, 8); ack_slot(a); check("rst_seq_ack0", a, 1);
    send_bits(8'h40, 8); ack_slot(a); check("rst_seq_ack1", a, 1);
    sb.push_back({1'b1, 8'hA5});
    send_bits(8'hA5, 8);
    sda_drv = 1'b1; wait_clk(Q);
    check("oen_before_rst", int'(bus.sda_oen), 1);
    rst_n = 1'b0;
    #1;
    check("oen_in_rst", int'(bus.sda_oen), 0);
    check("busy_in_rst", int'(bus.busy), 0);
    check("data_in_rst", int'(bus.byte_data), 0);
    wait_clk(3);
    rst_n = 1'b1;
    bus.scl_in = 1'b1; wait_clk(Q);
    bus.scl_in = 1'b0; wait_clk(Q);
    begin
      int fd_base, oen_base;
      fd_base = fd_cnt;
      oen_base = oen_cnt;
      send_bits(8'h78, 8); ack_slot(a);
      check("no_ack_without_start", a, 0);
      do_stop();
      wait_clk(12);
      check("post_rst_oen", oen_cnt - oen_base, 0);
      check("post_rst_fd", fd_cnt - fd_base, 0);
      check("post_rst_busy", int'(bus.busy), 0);
      check("post_rst_sb", sb.size(), 0);
    end
    frm[0] = 8'h78; frm[1] = 8'h40; frm[2] = 8'h3C;
    run_frame(3, 0);

`ifdef OLED_I2C_SLAVE_GLITCH_FILTER_EN
    glitch_en = 1'b1;
    frm[0] = 8'h78; frm[1] = 8'h40; frm[2] = 8'h96; frm[3] = 8'h69;
    run_frame(4, 0);
    glitch_en = 1'b0;
`endif

    // Randomised frames.
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) frm[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) frm[0] = 8'h78;
      run_frame(n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_i2c_slave.md
OLED_I2C_SLAVE -- requirements
Module: oled_i2c_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  OLED_CHIP_ADDR  7'h3C  7-bit target address answered.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  system clock; single clock domain.
  rst_n  in  1  reset, asynchronous, active-low.
  scl_in  in  1  bus SCL, asynchronous to clk.
  sda_in  in  1  bus SDA, asynchronous to clk.
  sda_out  out  1  constant 0; open-drain low level.
  sda_oen  out  1  1 = drive sda_out onto SDA (ACK); 0 = release.
  byte_valid  out  1  one-clk pulse, received command/data byte.
  byte_dc  out  1  D/C# of byte_data: 0 = command, 1 = GDDRAM data.
  byte_data  out  8  received byte; held until next byte_valid.
  busy  out  1  1 from address-match ACK until STOP or mismatching START.
  frame_done  out  1  one-clk pulse on STOP ending an addressed transaction.

Function
REQ-003 scl_in and sda_in SHALL pass a 2-FF synchroniser; all edges and conditions derive from the synchronised signals.
REQ-004 START SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high; a bit SHALL be sampled on SCL rising, MSB first.
REQ-005 States SHALL be IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE.
REQ-006 START in any state SHALL go to ADDR with bit counter cleared (repeated START included).
REQ-007 After 8 address bits: {addr,R/W} == {OLED_CHIP_ADDR,0} -> ADDR_ACK; otherwise -> IGNORE; reads SHALL NOT be acknowledged.
REQ-008 ACK SHALL assert sda_oen on the SCL falling edge ending bit 8 and deassert it on the following SCL falling edge.
REQ-009 CTRL SHALL receive the control byte: bit7 = Co, bit6 = D/C#; bits 5:0 ignored; control byte SHALL NOT produce byte_valid.
REQ-010 After CTRL_ACK: Co=1 -> exactly one DATA byte, then back to CTRL; Co=0 -> DATA repeats until STOP/START, all bytes with latched D/C#.
REQ-011 byte_valid SHALL pulse one clk after the 8th DATA bit is sampled, with byte_data/byte_dc valid in the same cycle.
REQ-012 Every DATA byte SHALL be ACKed; no NACK or clock stretching.
REQ-013 IGNORE SHALL keep sda_oen=0 and leave only on START or STOP.
REQ-014 STOP in any state SHALL go to IDLE; a partial byte SHALL be discarded without byte_valid; frame_done SHALL pulse only if busy was 1.
REQ-015 START and STOP detected in the same clk SHALL be impossible; SDA change coincident with SCL rising SHALL be treated as data, not START/STOP.

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, sda_oen=0, byte_valid=0, byte_dc=0, byte_data=8'h00, busy=0, frame_done=0, synchronisers to 1.
REQ-017 Reset mid-transaction SHALL release SDA within the asserting edge; after release the block SHALL wait for a new START.

Configuration
REQ-018 Macro OLED_I2C_SLAVE_GLITCH_FILTER_EN defined: a 3-sample majority filter SHALL follow each synchroniser (+2 clk latency); pulses of 1 clk SHALL be rejected.
REQ-019 Macro undefined: no filter; synchroniser output used directly; all other behaviour identical.

Verification
REQ-020 Bench scenarios:
  - START, 0x78, 0x00, 0xAE, 0xD5, 0x80, STOP -> all 5 bytes ACKed; 3 byte_valid, dc=0, data AE/D5/80; frame_done once.
  - START, 0x78, 0x40, 0xFF, 0x00, 0xAA, STOP -> 3 byte_valid dc=1 FF/00/AA; busy 1 through last ACK, 0 after STOP.
  - START, 0x78, 0x80, 0xAF, 0xC0, 0x55, STOP -> AF dc=0 then 55 dc=1; C0 control byte emits nothing.
  - START, 0x7A (addr 0x3D) or 0x79 (read) -> sda_oen never 1, no byte_valid, busy 0, no frame_done.
  - START, 0x78, 0x40, 4 bits of 0xF0, STOP -> no byte_valid for partial; frame_done pulses; next START, 0x78 ACKed.
  - rst_n low during DATA_ACK -> sda_oen 0 immediately; with filter macro, 1-clk SCL glitch -> no bit sampled.
